// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU among NUM_REQ valid/ready requesters,
// with a one-entry response register. Define ALU_ARB_STATS_EN to add per-requester grant counters.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     ReqValid,
    output logic [NUM_REQ-1:0]     ReqReady,
    input  logic [NUM_REQ*32-1:0]  ReqA,
    input  logic [NUM_REQ*32-1:0]  ReqB,
    input  logic [NUM_REQ*3-1:0]   ReqOp,
    output logic [31:0]            AluA,
    output logic [31:0]            AluB,
    output logic [2:0]             AluControl,
    input  logic [31:0]            AluResult,
    input  logic [3:0]             AluFlags,
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic [ID_W-1:0]        RspId,
    output logic [31:0]            RspResult,
    output logic [3:0]             RspFlags,
    output logic                   RspErr
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]  StatGrantCnt
`endif
);

    localparam logic [ID_W:0] NUM_REQ_W = NUM_REQ[ID_W:0];

    logic [ID_W-1:0] rr_ptr_r;
    logic            rsp_valid_r;
    logic [ID_W-1:0] rsp_id_r;
    logic [31:0]     rsp_result_r;
    logic [3:0]      rsp_flags_r;
    logic            rsp_err_r;

    logic            accept_en_s;
    logic            grant_vld_s;
    logic [ID_W-1:0] grant_idx_s;
    logic [31:0]     sel_a_s;
    logic [31:0]     sel_b_s;
    logic [2:0]      sel_op_s;

    // Index arithmetic modulo NUM_REQ; NUM_REQ need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W:0]   off);
        logic [ID_W:0] sum;
        logic [ID_W:0] wrapped;
        sum     = {1'b0, base} + off;
        wrapped = sum - NUM_REQ_W;
        return (sum >= NUM_REQ_W) ? wrapped[ID_W-1:0] : sum[ID_W-1:0];
    endfunction

    assign accept_en_s = !Reset && (!rsp_valid_r || RspReady);

    // Round-robin search starting at rr_ptr_r; idle index stays at rr_ptr_r.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = rr_ptr_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = wrap_add(rr_ptr_r, k[ID_W:0]);
            if (accept_en_s && !grant_vld_s && ReqValid[cand]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Operand mux onto the shared ALU and one-hot ready generation.
    always_comb begin
        sel_a_s  = ReqA[31:0];
        sel_b_s  = ReqB[31:0];
        sel_op_s = ReqOp[2:0];
        ReqReady = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == i[ID_W-1:0]) begin
                sel_a_s  = ReqA[i*32 +: 32];
                sel_b_s  = ReqB[i*32 +: 32];
                sel_op_s = ReqOp[i*3 +: 3];
            end else begin
                sel_a_s  = sel_a_s;
            end
            ReqReady[i] = grant_vld_s && (grant_idx_s == i[ID_W-1:0]);
        end
    end

    assign AluA       = sel_a_s;
    assign AluB       = sel_b_s;
    assign AluControl = {1'b0, sel_op_s[1:0]};

    // Response register and round-robin pointer; illegal ops yield zeroed result and flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rr_ptr_r     <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= 32'd0;
            rsp_flags_r  <= 4'd0;
            rsp_err_r    <= 1'b0;
        end else if (grant_vld_s) begin
            rr_ptr_r     <= wrap_add(grant_idx_s, {{ID_W{1'b0}}, 1'b1});
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= grant_idx_s;
            rsp_err_r    <= sel_op_s[2];
            rsp_result_r <= sel_op_s[2] ? 32'd0 : AluResult;
            rsp_flags_r  <= sel_op_s[2] ? 4'd0 : AluFlags;
        end else if (RspReady) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    assign RspValid  = rsp_valid_r;
    assign RspId     = rsp_id_r;
    assign RspResult = rsp_result_r;
    assign RspFlags  = rsp_flags_r;
    assign RspErr    = rsp_err_r;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt_r [NUM_REQ];

    // Saturating per-requester accept counters.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Reset) begin
                grant_cnt_r[i] <= 16'd0;
            end else if (grant_vld_s && (grant_idx_s == i[ID_W-1:0]) &&
                         (grant_cnt_r[i] != 16'hFFFF)) begin
                grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign StatGrantCnt[g*16 +: 16] = grant_cnt_r[g];
    end
`endif

endmodule
